// File: rtl/coin_detector.sv
// rtl/coin_detector.sv - coin chute front end: input conditioning, width classification, hand-off and gates

// Two-flop synchroniser followed by a stable-sample debouncer
module coin_detector_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          samp_q, samp_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronise, then count consecutive equal samples; the filtered level
    // follows only once the sample has been stable for DB_CYCLES samples.
    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        samp_d = samp_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (s2_q != samp_q) begin
            samp_d = s2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CW'(DB_CYCLES)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q >= CW'(DB_CYCLES - 1)) begin
                filt_d = samp_q;
            end
        end
    end

    // Conditioning state register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            samp_q <= 1'b0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            samp_q <= samp_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
endmodule

module coin_detector #(
    parameter int DB_CYCLES   = 4,
    parameter int W_5         = 100,
    parameter int W_10        = 150,
    parameter int W_25        = 200,
    parameter int W_100       = 300,
    parameter int W_200       = 400,
    parameter int TOL         = 20,
    parameter int JAM_CYCLES  = 2000,
    parameter int GATE_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       coin_reject,
    input  logic       eat_coins,
    input  logic       coin_sensor,
    input  logic       return_btn,
    output logic       coin_insert,
    output logic [2:0] coin_type,
    output logic       return_coin,
    output logic       vault_gate,
    output logic       reject_gate,
    output logic       busy,
    output logic       jam
);
    localparam int          GW     = $clog2(GATE_CYCLES + 1);
    localparam logic [11:0] W_SAT  = 12'hFFF;

    logic          sens_f, btn_f;
    logic          sens_prev_q, sens_prev_d;
    logic          btn_prev_q, btn_prev_d;
    logic [11:0]   width_q, width_d;
    logic          jam_q, jam_d;
    logic          coin_q, coin_d;
    logic [2:0]    type_q, type_d;
    logic          ret_q, ret_d;
    logic [GW-1:0] vault_q, vault_d;
    logic [GW-1:0] reject_q, reject_d;
    logic          sens_rise, sens_fall, btn_rise;

    coin_detector_debounce #(.DB_CYCLES(DB_CYCLES)) u_sens_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin_sensor),
        .filt (sens_f)
    );

    coin_detector_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (return_btn),
        .filt (btn_f)
    );

    function automatic logic in_band(input int w, input int nom);
        return (w >= nom - TOL) && (w <= nom + TOL);
    endfunction

    // First matching denomination wins; anything else is presented as invalid
    function automatic logic [2:0] classify(input logic [11:0] width);
        int w;
        w = int'(width);
        if (in_band(w, W_5))        return 3'b001;
        else if (in_band(w, W_10))  return 3'b010;
        else if (in_band(w, W_25))  return 3'b011;
        else if (in_band(w, W_100)) return 3'b100;
        else if (in_band(w, W_200)) return 3'b101;
        else                        return 3'b000;
    endfunction

    assign sens_rise = sens_f & ~sens_prev_q;
    assign sens_fall = ~sens_f & sens_prev_q;
    assign btn_rise  = btn_f & ~btn_prev_q;

    // Width measurement, jam detection, pending flags and gate timers
    always_comb begin
        sens_prev_d = sens_f;
        btn_prev_d  = btn_f;
        width_d     = width_q;
        jam_d       = jam_q;
        coin_d      = coin_q;
        type_d      = type_q;
        ret_d       = ret_q;
        vault_d     = vault_q;
        reject_d    = reject_q;

        // The rise cycle is itself the first high cycle, so the count restarts at 1
        if (sens_rise) begin
            width_d = 12'd1;
        end else if (sens_f && width_q != W_SAT) begin
            width_d = width_q + 12'd1;
        end

        if (sens_f && width_d == 12'(JAM_CYCLES)) begin
            jam_d = 1'b1;
        end

        // A return request outranks a coin, matching the casher's own order
        if (en && ret_q) begin
            ret_d = 1'b0;
        end else if (en && coin_q) begin
            coin_d = 1'b0;
            type_d = 3'b000;
        end

        // A coin consumed on this edge frees the slot for a coin finishing now
        if (sens_fall && !jam_q && !coin_d) begin
            coin_d = 1'b1;
            type_d = classify(width_q);
        end

        if (btn_rise && !ret_q) begin
            ret_d = 1'b1;
        end

        if (eat_coins) begin
            vault_d = GW'(GATE_CYCLES);
        end else if (vault_q != '0) begin
            vault_d = vault_q - 1'b1;
        end

        if (coin_reject && !eat_coins) begin
            reject_d = GW'(GATE_CYCLES);
        end else if (reject_q != '0) begin
            reject_d = reject_q - 1'b1;
        end
    end

    // Main state register
    always_ff @(posedge clk) begin
        if (rst) begin
            sens_prev_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            width_q     <= '0;
            jam_q       <= 1'b0;
            coin_q      <= 1'b0;
            type_q      <= 3'b000;
            ret_q       <= 1'b0;
            vault_q     <= '0;
            reject_q    <= '0;
        end else begin
            sens_prev_q <= sens_prev_d;
            btn_prev_q  <= btn_prev_d;
            width_q     <= width_d;
            jam_q       <= jam_d;
            coin_q      <= coin_d;
            type_q      <= type_d;
            ret_q       <= ret_d;
            vault_q     <= vault_d;
            reject_q    <= reject_d;
        end
    end

    assign coin_insert = coin_q;
    assign coin_type   = type_q;
    assign return_coin = ret_q;
    assign vault_gate  = (vault_q != '0);
    assign reject_gate = (reject_q != '0);
    assign busy        = coin_q;
    assign jam         = jam_q;
endmodule

// File: tb/tb_coin_detector.sv
// tb/tb_coin_detector.sv - self-checking bench for coin_detector
module tb_coin_detector;
    localparam int DB = 4;
    localparam int LAT = 1 + 2 + DB + 1;

    logic       clk = 1'b0;
    logic       rst, en, coin_reject, eat_coins, coin_sensor, return_btn;
    logic       coin_insert, return_coin, vault_gate, reject_gate, busy, jam;
    logic [2:0] coin_type;

    int tests = 0;
    int fails = 0;

    coin_detector dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .coin_reject (coin_reject),
        .eat_coins   (eat_coins),
        .coin_sensor (coin_sensor),
        .return_btn  (return_btn),
        .coin_insert (coin_insert),
        .coin_type   (coin_type),
        .return_coin (return_coin),
        .vault_gate  (vault_gate),
        .reject_gate (reject_gate),
        .busy        (busy),
        .jam         (jam)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Denomination from pulse width: nominal widths and tolerance, first match wins
    function automatic logic [2:0] ref_type(input int w);
        int nom [5] = '{100, 150, 200, 300, 400};
        for (int d = 0; d < 5; d++) begin
            if (w >= nom[d] - 20 && w <= nom[d] + 20) return 3'(d + 1);
        end
        return 3'b000;
    endfunction

    task automatic send_pulse(input int n);
        coin_sensor = 1'b1;
        repeat (n) tick();
        coin_sensor = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; coin_reject = 1'b0; eat_coins = 1'b0;
        coin_sensor = 1'b0; return_btn = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({coin_insert, return_coin, vault_gate, reject_gate, busy, jam} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {coin_insert, return_coin, vault_gate, reject_gate, busy, jam});
        end
        tests++;
        if (coin_type !== 3'b000) begin
            fails++;
            $display("FAIL reset_type: got %b, required 000", coin_type);
        end
    endtask

    task automatic test_classify();
        int widths [$] = '{300, 250, 179, 180, 100, 120, 121, 420, 421, 80, 79};
        repeat (8) widths.push_back(60 + int'($urandom % 391));
        en = 1'b1;
        foreach (widths[k]) begin
            int w = widths[k];
            logic [2:0] exp = ref_type(w);
            int lat = 0;
            send_pulse(w);
            while (!coin_insert && lat < 40) begin
                tick();
                lat++;
            end
            tests++;
            if (lat !== LAT) begin
                fails++;
                $display("FAIL latency w=%0d: got %0d edges, required %0d", w, lat, LAT);
            end
            tests++;
            if (coin_type !== exp || busy !== 1'b1) begin
                fails++;
                $display("FAIL class w=%0d: got type %b busy %b, required type %b busy 1",
                         w, coin_type, busy, exp);
            end
            tick();
            tests++;
            if (coin_insert !== 1'b0 || coin_type !== 3'b000) begin
                fails++;
                $display("FAIL consume w=%0d: got insert %b type %b, required 0 000",
                         w, coin_insert, coin_type);
            end
            repeat (12) tick();
        end
    endtask

    task automatic test_priority();
        int n = 0;
        en = 1'b0;
        send_pulse(100);
        while (!coin_insert && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (coin_insert !== 1'b1 || coin_type !== 3'b001) begin
            fails++;
            $display("FAIL pend_5c: got insert %b type %b, required 1 001", coin_insert, coin_type);
        end
        send_pulse(300);
        repeat (20) tick();
        tests++;
        if (coin_type !== 3'b001) begin
            fails++;
            $display("FAIL discard_while_busy: got type %b, required 001", coin_type);
        end
        return_btn = 1'b1;
        repeat (10) tick();
        return_btn = 1'b0;
        n = 0;
        while (!return_coin && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (return_coin !== 1'b1 || coin_insert !== 1'b1) begin
            fails++;
            $display("FAIL both_pending: got ret %b insert %b, required 1 1", return_coin, coin_insert);
        end
        en = 1'b1;
        tick();
        tests++;
        if (return_coin !== 1'b0 || coin_insert !== 1'b1 || coin_type !== 3'b001) begin
            fails++;
            $display("FAIL return_first: got ret %b insert %b type %b, required 0 1 001",
                     return_coin, coin_insert, coin_type);
        end
        tick();
        tests++;
        if (coin_insert !== 1'b0 || coin_type !== 3'b000) begin
            fails++;
            $display("FAIL coin_second: got insert %b type %b, required 0 000", coin_insert, coin_type);
        end
        repeat (12) tick();
    endtask

    task automatic test_glitch();
        logic [1:0] seen = 2'b00;
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int g = int'($urandom_range(3, 1));
            if (i % 2 == 0) coin_sensor = 1'b1;
            else            return_btn  = 1'b1;
            repeat (g) tick();
            coin_sensor = 1'b0;
            return_btn  = 1'b0;
            repeat (12) begin
                tick();
                seen |= {coin_insert, return_coin};
            end
        end
        tests++;
        if (seen !== 2'b00 || coin_type !== 3'b000) begin
            fails++;
            $display("FAIL glitch: got seen %b type %b, required 00 000", seen, coin_type);
        end
        en = 1'b1;
    endtask

    task automatic test_gates();
        int vh, rh;
        eat_coins = 1'b1; coin_reject = 1'b1;
        tick();
        eat_coins = 1'b0; coin_reject = 1'b0;
        vh = 0; rh = 0;
        repeat (60) begin
            if (vault_gate)  vh++;
            if (reject_gate) rh++;
            tick();
        end
        tests++;
        if (vh !== 50 || rh !== 0) begin
            fails++;
            $display("FAIL gate_eat: got vault %0d reject %0d cycles, required 50 0", vh, rh);
        end
        coin_reject = 1'b1;
        tick();
        coin_reject = 1'b0;
        vh = 0; rh = 0;
        repeat (60) begin
            if (vault_gate)  vh++;
            if (reject_gate) rh++;
            tick();
        end
        tests++;
        if (vh !== 0 || rh !== 50) begin
            fails++;
            $display("FAIL gate_reject: got vault %0d reject %0d cycles, required 0 50", vh, rh);
        end
        eat_coins = 1'b1;
        tick();
        eat_coins = 1'b0;
        vh = 1;
        repeat (19) begin
            tick();
            if (vault_gate) vh++;
        end
        eat_coins = 1'b1;
        tick();
        eat_coins = 1'b0;
        repeat (60) begin
            if (vault_gate) vh++;
            tick();
        end
        tests++;
        if (vh !== 70) begin
            fails++;
            $display("FAIL gate_retrigger: got vault %0d cycles, required 70", vh);
        end
    endtask

    task automatic test_jam();
        int first = -1;
        logic coin_seen = 1'b0;
        int n = 0;
        en = 1'b1;
        coin_sensor = 1'b1;
        for (int t = 1; t <= 2100; t++) begin
            tick();
            if (jam && first < 0) first = t;
        end
        coin_sensor = 1'b0;
        repeat (40) begin
            tick();
            coin_seen |= coin_insert;
        end
        // Filtered high starts at tick 7, so the 2000th filtered-high cycle is tick 2006
        tests++;
        if (first < 2006 || first > 2010) begin
            fails++;
            $display("FAIL jam_time: got first jam tick %0d, required 2006..2010", first);
        end
        tests++;
        if (jam !== 1'b1 || coin_seen !== 1'b0) begin
            fails++;
            $display("FAIL jam_no_coin: got jam %b coin_seen %b, required 1 0", jam, coin_seen);
        end
        en = 1'b0;
        return_btn = 1'b1;
        repeat (10) tick();
        return_btn = 1'b0;
        while (!return_coin && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (return_coin !== 1'b1) begin
            fails++;
            $display("FAIL jam_return: got ret %b, required 1", return_coin);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (jam !== 1'b0 || return_coin !== 1'b0 || coin_insert !== 1'b0) begin
            fails++;
            $display("FAIL jam_reset: got jam %b ret %b insert %b, required 0 0 0",
                     jam, return_coin, coin_insert);
        end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_priority();
        test_glitch();
        test_gates();
        test_jam();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
